// File: rtl/valu_pipe.sv
// Lane-wise vector ALU (8/16/32-bit lanes) feeding an in-order result FIFO; saturating SADD/SSUB only with VALU_PIPE_SAT_EN.
// Latency STAGES cycles issue-to-result; issue is credit-gated on pipeline + FIFO occupancy, results wait for result_ready_i.

module valu_lane #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  logic [W-1:0] sum;
  logic [W-1:0] dif;
  logic         lt;

  assign sum = a + b;
  assign dif = a - b;
  assign lt  = $signed(a) < $signed(b);

`ifdef VALU_PIPE_SAT_EN
  logic         add_ovf;
  logic         sub_ovf;
  logic [W-1:0] sat_val;

  // Overflow only when the wrapped sign disagrees with the true sign.
  assign add_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign sub_ovf = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
  assign sat_val = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif

  always_comb begin
    y = sum;
    case (op)
      3'd0: y = sum;
      3'd1: y = dif;
      3'd2: y = lt ? a : b;
      3'd3: y = lt ? b : a;
      3'd4: y = a & b;
      3'd5: y = a ^ b;
`ifdef VALU_PIPE_SAT_EN
      3'd6: y = add_ovf ? sat_val : sum;
      3'd7: y = sub_ovf ? sat_val : dif;
`else
      3'd6: y = sum;
      3'd7: y = dif;
`endif
      default: y = sum;
    endcase
  end

endmodule

module valu_pipe #(
  parameter int XLEN          = 32,
  parameter int STAGES        = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [2:0]               op_i,
  input  logic [1:0]               ew_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int NW = XLEN / 32;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]          r8, r16, r32, alu_res;
  logic                     issue, pop;
  logic                     push_vld;
  logic [XLEN-1:0]          push_res;
  logic [TRANS_ID_BITS-1:0] push_tid;
  logic [3:0]               pipe_cnt;
  logic [3:0]               inflight;

  logic [XLEN-1:0]          fifo_res [FIFO_DEPTH];
  logic [TRANS_ID_BITS-1:0] fifo_tid [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            cnt;

  for (genvar w = 0; w < NW; w++) begin : g_word
    for (genvar l = 0; l < 4; l++) begin : g_b8
      valu_lane #(.W(8)) u_lane (
        .a  (operand_a_i[w*32+l*8 +: 8]),
        .b  (operand_b_i[w*32+l*8 +: 8]),
        .op (op_i),
        .y  (r8[w*32+l*8 +: 8])
      );
    end
    for (genvar l = 0; l < 2; l++) begin : g_b16
      valu_lane #(.W(16)) u_lane (
        .a  (operand_a_i[w*32+l*16 +: 16]),
        .b  (operand_b_i[w*32+l*16 +: 16]),
        .op (op_i),
        .y  (r16[w*32+l*16 +: 16])
      );
    end
    valu_lane #(.W(32)) u_lane32 (
      .a  (operand_a_i[w*32 +: 32]),
      .b  (operand_b_i[w*32 +: 32]),
      .op (op_i),
      .y  (r32[w*32 +: 32])
    );
  end

  always_comb begin
    alu_res = r32;
    case (ew_i)
      2'd0:    alu_res = r8;
      2'd1:    alu_res = r16;
      default: alu_res = r32;
    endcase
  end

  assign issue = valid_i & ready_o & ~flush_i;
  assign pop   = result_valid_o & result_ready_i & ~flush_i;

  if (STAGES > 1) begin : g_pipe
    logic [STAGES-2:0]        vld;
    logic [XLEN-1:0]          res [STAGES-1];
    logic [TRANS_ID_BITS-1:0] tid [STAGES-1];

    always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
        vld <= '0;
      end else begin
        vld[0] <= issue;
        for (int i = 1; i < STAGES - 1; i++) vld[i] <= vld[i-1];
      end
    end

    // Payload needs no reset: it is only observed alongside its valid bit.
    always_ff @(posedge clk_i) begin
      res[0] <= alu_res;
      tid[0] <= trans_id_i;
      for (int i = 1; i < STAGES - 1; i++) begin
        res[i] <= res[i-1];
        tid[i] <= tid[i-1];
      end
    end

    always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < STAGES - 1; i++) pipe_cnt = pipe_cnt + 4'(vld[i]);
    end

    assign push_vld = vld[STAGES-2];
    assign push_res = res[STAGES-2];
    assign push_tid = tid[STAGES-2];
  end else begin : g_nopipe
    assign pipe_cnt = '0;
    assign push_vld = issue;
    assign push_res = alu_res;
    assign push_tid = trans_id_i;
  end

  // Every accepted op owns a FIFO slot from issue, so the FIFO can never overflow.
  assign inflight = 4'(cnt) + pipe_cnt;
  assign ready_o  = inflight < 4'(FIFO_DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push_vld) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_vld) begin
      fifo_res[wr_ptr] <= push_res;
      fifo_tid[wr_ptr] <= push_tid;
    end
  end

  assign result_valid_o = (cnt != '0);
  assign result_o       = result_valid_o ? fifo_res[rd_ptr] : '0;
  assign trans_id_o     = result_valid_o ? fifo_tid[rd_ptr] : '0;

endmodule

// File: doc/valu_pipe.md
VALU_PIPE -- requirements
Module: valu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are multiples of 32.
REQ-002 SHALL have parameter STAGES, default 2, issue-to-result latency in cycles; legal range 1..4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, result buffer entries; legal range 1..8.
REQ-004 SHALL have parameter TRANS_ID_BITS, default 3, scoreboard tag width.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit; reset is synchronous and active-low.
REQ-007 SHALL have port flush_i, input, 1 bit, discards all in-flight and buffered operations.
REQ-008 SHALL have port valid_i, input, 1 bit, issue request.
REQ-009 SHALL have port ready_o, output, 1 bit, issue credit available.
REQ-010 SHALL have ports operand_a_i and operand_b_i, input, XLEN bits each, source operands.
REQ-011 SHALL have port op_i, input, 3 bits, operation code.
REQ-012 SHALL have port ew_i, input, 2 bits, lane width selector.
REQ-013 SHALL have port trans_id_i, input, TRANS_ID_BITS bits, issue tag.
REQ-014 SHALL have port result_valid_o, output, 1 bit, FIFO head valid.
REQ-015 SHALL have port result_ready_i, input, 1 bit, writeback accepts head.
REQ-016 SHALL have port result_o, output, XLEN bits, head result.
REQ-017 SHALL have port trans_id_o, output, TRANS_ID_BITS bits, head tag.

Function
REQ-018 SHALL accept an operation when valid_i and ready_o are both high at a rising edge and flush_i is low.
REQ-019 SHALL compute lane-wise with ew_i 0=8-bit, 1=16-bit, 2=32-bit and 3=32-bit (reserved alias); no carry or borrow crosses lane boundaries.
REQ-020 SHALL implement op_i 0 ADD (wrap), 1 SUB (wrap), 2 MINS (signed), 3 MAXS (signed), 4 AND, 5 XOR, 6 SADD, 7 SSUB.
REQ-021 SHALL register the result and tag through STAGES-1 pipeline registers, then write them into the FIFO, so result_valid_o rises exactly STAGES cycles after acceptance when the FIFO is empty.
REQ-022 SHALL present results in issue order only.
REQ-023 SHALL pop the FIFO head at a rising edge where result_valid_o and result_ready_i are both high; push and pop in the same cycle SHALL both take effect.
REQ-024 SHALL drive ready_o high only when (valid pipeline entries + FIFO occupancy) < FIFO_DEPTH, computed from registered state only, with no credit for a same-cycle pop.
REQ-025 SHALL never drop or overwrite a result while result_ready_i is held low; the pipeline stalls by credit, never by back-pressure.
REQ-026 SHALL drive result_o and trans_id_o to zero whenever result_valid_o is low.
REQ-027 SHALL, on flush_i high at a rising edge, clear all pipeline valid bits and empty the FIFO; a same-cycle issue or pop is ignored, and ready_o is high in the next cycle.
REQ-028 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, when rst_ni is low at a rising edge, clear all pipeline valid bits, FIFO pointers and count; rst_ni takes priority over flush_i.
REQ-030 SHALL hold result_valid_o=0, result_o=0, trans_id_o=0 and ready_o=1 after reset.
REQ-031 SHALL discard operations in flight when reset is asserted mid-operation; no result SHALL appear after release.

Configuration
REQ-032 SHALL honour macro VALU_PIPE_SAT_EN: when defined, SADD and SSUB saturate each lane to its signed min/max.
REQ-033 SHALL, when VALU_PIPE_SAT_EN is undefined, execute op_i 6 as ADD and op_i 7 as SUB, and synthesise no saturation logic.

Verification
REQ-034 SHALL cover ew=0, ADD, a=0x7F01FF80, b=0x01010180 -> result_o=0x80020000, valid after exactly STAGES cycles.
REQ-035 SHALL cover VALU_PIPE_SAT_EN defined, ew=0, SADD with the same operands -> 0x7F020080; macro undefined -> 0x80020000.
REQ-036 SHALL cover SUB with a=0x00010000, b=0x00000001: ew=1 -> 0x0001FFFF; ew=2 -> 0x0000FFFF.
REQ-037 SHALL cover FIFO_DEPTH=2, result_ready_i=0, three back-to-back issues -> ready_o low after the second issue, third held off, both results retained in order with tags 1 then 2.
REQ-038 SHALL cover flush_i asserted with one op in the pipeline and one in the FIFO -> result_valid_o=0 and ready_o=1 the next cycle, and no stale result appears later.
REQ-039 SHALL cover rst_ni low for one cycle mid-stream -> all outputs at reset values next cycle, and a fresh issue completes normally.
